// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the MEM stage.
// Contents: control-bus bit indices, IC_send destination field bounds,
// the memory-access FSM state encoding, and an alignment helper.
package mips_pkg;

  // ctrl bus: [4]MemRead [3]MemWrite [2]Branch [1]RegWrite [0]MemtoReg
  localparam int unsigned CTRL_W        = 5;
  localparam int unsigned CTRL_MEMREAD  = 4;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_BRANCH   = 2;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  // IC_send_ex_op: destination register lives in the low field
  localparam int unsigned IC_W     = 10;
  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned DEST_MSB = 4;
  localparam int unsigned REG_W    = DEST_MSB - DEST_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/gnt/rvalid port.
// master: the MEM stage (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
// slave : the data memory or its bus adapter
interface memory_access_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_fsm.sv
// Memory-access controller for the MEM stage: FSM, timeout counter and
// data-memory handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid           EX/MEM holds a valid instruction
//   i_memread/write   control bits of that instruction
//   i_addr, i_wdata   access address and store data (from EX/MEM)
//   o_stall           freeze upstream stages
//   o_done            access finished this cycle, MEM/WB may load
//   o_misalign        current instruction is a misaligned access (IDLE only)
//   o_rdata           captured load data (0 after timeout)
//   o_misalign_err    sticky misalignment flag
//   o_bus_err         sticky timeout flag
//   dmem              data-memory port (master)
module mem_access_fsm
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic                   i_memread,
  input  logic                   i_memwrite,
  input  logic [DATA_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]      i_wdata,
  output logic                   o_stall,
  output logic                   o_done,
  output logic                   o_misalign,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_misalign_err,
  output logic                   o_bus_err,
  memory_access_stage_if.master  dmem
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic [TW-1:0]     r_timer;
  logic [DATA_W-1:0] r_rdata;
  logic              r_misalign_err;
  logic              r_bus_err;

  logic w_mem;
  logic w_aligned;
  logic w_start;
  logic w_timeout;
  logic w_is_load;

  assign w_mem     = i_valid & (i_memread | i_memwrite);
  assign w_aligned = word_aligned(i_addr[1:0]);
  assign w_start   = w_mem & w_aligned;
  assign w_timeout = (r_timer == TMAX);
  // MemWrite wins if both control bits are set
  assign w_is_load = ~i_memwrite;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_next = REQ;
      REQ: begin
        // gnt+rvalid together on a load completes without visiting WAIT
        if (dmem.dmem_gnt)
          w_next = (!w_is_load || dmem.dmem_rvalid) ? DONE : WAIT;
        else if (w_timeout)
          w_next = DONE;
      end
      WAIT: if (dmem.dmem_rvalid || w_timeout) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic; bus fields are zero outside REQ so the port is quiet when idle
  always_comb begin
    o_stall         = 1'b0;
    o_done          = 1'b0;
    o_misalign      = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        o_stall    = w_start;
        o_misalign = w_mem & ~w_aligned;
      end
      REQ: begin
        o_stall         = 1'b1;
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = i_memwrite;
        dmem.dmem_addr  = {i_addr[DATA_W-1:2], 2'b00};
        dmem.dmem_wdata = i_wdata;
      end
      WAIT: o_stall = 1'b1;
      DONE: o_done  = 1'b1;
      default: ;
    endcase
  end

  // Timer, load-data capture and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer        <= '0;
      r_rdata        <= '0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_start) r_rdata <= '0;
          if (w_mem && !w_aligned) r_misalign_err <= 1'b1;
        end
        REQ: begin
          if (dmem.dmem_gnt) begin
            r_timer <= '0;
            if (w_is_load && dmem.dmem_rvalid) r_rdata <= dmem.dmem_rdata;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            r_rdata <= dmem.dmem_rdata;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_timer <= '0;
      endcase
    end
  end

  assign o_rdata        = r_rdata;
  assign o_misalign_err = r_misalign_err;
  assign o_bus_err      = r_bus_err;

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM and MEM/WB registers, runs loads/stores through
// mem_access_fsm over the dmem interface and stalls upstream while an
// access is outstanding.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   alu_result_in, mem_data_in,
//   ic_send_in, zero_in, ctrl_in,
//   ex_valid                            EX-stage outputs
//   stall_mem                           freeze IF..EX
//   mem_forward_data, mem_dest,
//   mem_regwrite                        forwarding info of the instr in MEM
//   pc_src                              branch taken (Branch & Zero & valid)
//   dmem                                data-memory port (master modport)
//   wb_valid, wb_data, wb_dest,
//   wb_regwrite                         MEM/WB register
//   misalign_err, bus_err               sticky error flags
module memory_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [IC_W-1:0]       ic_send_in,
  input  logic                  zero_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic                  ex_valid,
  output logic                  stall_mem,
  output logic [DATA_W-1:0]     mem_forward_data,
  output logic [REG_W-1:0]      mem_dest,
  output logic                  mem_regwrite,
  output logic                  pc_src,
  memory_access_stage_if.master dmem,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_W-1:0]      wb_dest,
  output logic                  wb_regwrite,
  output logic                  misalign_err,
  output logic                  bus_err
);

  // EX/MEM register
  logic              r_exm_valid;
  logic [DATA_W-1:0] r_exm_alu;
  logic [DATA_W-1:0] r_exm_wdata;
  logic [REG_W-1:0]  r_exm_dest;
  logic [CTRL_W-1:0] r_exm_ctrl;
  logic              r_exm_zero;

  // MEM/WB register
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_W-1:0]  r_wb_dest;
  logic              r_wb_regwrite;

  logic              w_stall;
  logic              w_done;
  logic              w_misalign;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused_ic;

  // Upper IC_send bits belong to later stages
  assign w_unused_ic = ^ic_send_in[IC_W-1:DEST_MSB+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exm_valid <= 1'b0;
      r_exm_alu   <= '0;
      r_exm_wdata <= '0;
      r_exm_dest  <= '0;
      r_exm_ctrl  <= '0;
      r_exm_zero  <= 1'b0;
    end else if (!w_stall) begin
      r_exm_valid <= ex_valid;
      if (ex_valid) begin
        r_exm_alu   <= alu_result_in;
        r_exm_wdata <= mem_data_in;
        r_exm_dest  <= ic_send_in[DEST_MSB:DEST_LSB];
        r_exm_ctrl  <= ctrl_in;
        r_exm_zero  <= zero_in;
      end else begin
        r_exm_alu   <= '0;
        r_exm_wdata <= '0;
        r_exm_dest  <= '0;
        r_exm_ctrl  <= '0;
        r_exm_zero  <= 1'b0;
      end
    end
  end

  mem_access_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (r_exm_valid),
    .i_memread      (r_exm_ctrl[CTRL_MEMREAD]),
    .i_memwrite     (r_exm_ctrl[CTRL_MEMWRITE]),
    .i_addr         (r_exm_alu),
    .i_wdata        (r_exm_wdata),
    .o_stall        (w_stall),
    .o_done         (w_done),
    .o_misalign     (w_misalign),
    .o_rdata        (w_rdata),
    .o_misalign_err (misalign_err),
    .o_bus_err      (bus_err),
    .dmem           (dmem)
  );

  // A finished access retires with its data; a stall or a misaligned access
  // retires a bubble; otherwise the instruction passes through in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_dest     <= '0;
      r_wb_regwrite <= 1'b0;
    end else if (w_done) begin
      r_wb_valid    <= r_exm_valid;
      r_wb_data     <= r_exm_ctrl[CTRL_MEMTOREG] ? w_rdata : r_exm_alu;
      r_wb_dest     <= r_exm_dest;
      r_wb_regwrite <= r_exm_valid & r_exm_ctrl[CTRL_REGWRITE];
    end else if (w_stall || !r_exm_valid || w_misalign) begin
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_dest     <= '0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_valid    <= 1'b1;
      r_wb_data     <= r_exm_alu;
      r_wb_dest     <= r_exm_dest;
      r_wb_regwrite <= r_exm_ctrl[CTRL_REGWRITE];
    end
  end

  assign stall_mem        = w_stall;
  assign mem_forward_data = r_exm_alu;
  assign mem_dest         = r_exm_dest;
  // A misaligned access never writes back, so it must not be forwarded either
  assign mem_regwrite     = r_exm_valid & r_exm_ctrl[CTRL_REGWRITE] & ~w_misalign;
  assign pc_src           = r_exm_valid & r_exm_ctrl[CTRL_BRANCH] & r_exm_zero;

  assign wb_valid    = r_wb_valid;
  assign wb_data     = r_wb_data;
  assign wb_dest     = r_wb_dest;
  assign wb_regwrite = r_wb_regwrite;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result_in;
  logic [31:0] mem_data_in;
  logic [9:0]  ic_send_in;
  logic        zero_in;
  logic [4:0]  ctrl_in;
  logic        ex_valid;
  logic        stall_mem;
  logic [31:0] mem_forward_data;
  logic [4:0]  mem_dest;
  logic        mem_regwrite;
  logic        pc_src;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_regwrite;
  logic        misalign_err;
  logic        bus_err;

  memory_access_stage_if #(.DATA_W(32)) dmem_bus ();

  memory_access_stage #(
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_result_in    (alu_result_in),
    .mem_data_in      (mem_data_in),
    .ic_send_in       (ic_send_in),
    .zero_in          (zero_in),
    .ctrl_in          (ctrl_in),
    .ex_valid         (ex_valid),
    .stall_mem        (stall_mem),
    .mem_forward_data (mem_forward_data),
    .mem_dest         (mem_dest),
    .mem_regwrite     (mem_regwrite),
    .pc_src           (pc_src),
    .dmem             (dmem_bus),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data),
    .wb_dest          (wb_dest),
    .wb_regwrite      (wb_regwrite),
    .misalign_err     (misalign_err),
    .bus_err          (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        rw;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [4:0] C_ALU    = 5'b00010;  // RegWrite
  localparam logic [4:0] C_LW     = 5'b10011;  // MemRead RegWrite MemtoReg
  localparam logic [4:0] C_SW     = 5'b01000;  // MemWrite
  localparam logic [4:0] C_BRANCH = 5'b00100;  // Branch

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] dst, input logic rw);
    exp_t e;
    e.data = d;
    e.dest = dst;
    e.rw   = rw;
    sb_q.push_back(e);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Present one instruction for one cycle; returns at the negedge when it sits in MEM
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                       input logic [4:0] ctrl, input logic z);
    alu_result_in = alu;
    mem_data_in   = wd;
    ic_send_in    = {5'b10101, dst};
    ctrl_in       = ctrl;
    zero_in       = z;
    ex_valid      = 1'b1;
    tick();
    ex_valid      = 1'b0;
    alu_result_in = '0;
    mem_data_in   = '0;
    ic_send_in    = '0;
    ctrl_in       = '0;
    zero_in       = 1'b0;
  endtask

  // Scoreboard monitor: every retirement must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got retirement data=0x%08h dest=%0d, expected none",
                 wb_data, wb_dest);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_dest", 32'(wb_dest), 32'(e.dest));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    rst_n = 1'b0;
    alu_result_in = '0;
    mem_data_in = '0;
    ic_send_in = '0;
    zero_in = 1'b0;
    ctrl_in = '0;
    ex_valid = 1'b0;
    dmem_bus.dmem_gnt = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata = '0;
    tick();
    tick();
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_stall", 32'(stall_mem), 0);
    chk("rst_req", 32'(dmem_bus.dmem_req), 0);
    chk("rst_misalign", 32'(misalign_err), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_mem_rw", 32'(mem_regwrite), 0);
    rst_n = 1'b1;
    tick();

    // 1. ALU op, zero-wait
    push(32'h10, 5'd5, 1'b1);
    issue(32'h10, 32'h0, 5'd5, C_ALU, 1'b0);
    chk("alu_stall", 32'(stall_mem), 0);
    chk("alu_fwd", mem_forward_data, 32'h10);
    chk("alu_mem_dest", 32'(mem_dest), 5);
    chk("alu_mem_rw", 32'(mem_regwrite), 1);
    chk("alu_req", 32'(dmem_bus.dmem_req), 0);
    tick();
    chk("alu_wb_latency", 32'(wb_valid), 1);

    // Branch taken / not taken
    push(32'h100, 5'd0, 1'b0);
    issue(32'h100, 32'h0, 5'd0, C_BRANCH, 1'b1);
    chk("br_taken_pcsrc", 32'(pc_src), 1);
    tick();
    chk("bubble_pcsrc", 32'(pc_src), 0);
    push(32'h104, 5'd0, 1'b0);
    issue(32'h104, 32'h0, 5'd0, C_BRANCH, 1'b0);
    chk("br_nt_pcsrc", 32'(pc_src), 0);
    tick();

    // 2. lw 0x40, gnt immediate, rvalid next cycle
    push(32'hDEADBEEF, 5'd8, 1'b1);
    issue(32'h40, 32'h0, 5'd8, C_LW, 1'b0);
    stalls = 0;
    if (stall_mem) stalls++;
    tick();
    chk("lw_req", 32'(dmem_bus.dmem_req), 1);
    chk("lw_addr", dmem_bus.dmem_addr, 32'h40);
    chk("lw_we", 32'(dmem_bus.dmem_we), 0);
    if (stall_mem) stalls++;
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    chk("lw_req_dropped", 32'(dmem_bus.dmem_req), 0);
    chk("lw_fwd_stable", mem_forward_data, 32'h40);
    chk("lw_dest_stable", 32'(mem_dest), 8);
    if (stall_mem) stalls++;
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata = '0;
    chk("lw_done_stall", 32'(stall_mem), 0);
    chk("lw_stall_cycles", 32'(stalls), 3);
    tick();

    // 3. sw 0x44 / 0x1234, gnt on the 4th REQ cycle
    push(32'h44, 5'd3, 1'b0);
    issue(32'h44, 32'h1234, 5'd3, C_SW, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_req", 32'(dmem_bus.dmem_req), 1);
      chk("sw_addr", dmem_bus.dmem_addr, 32'h44);
      chk("sw_wdata", dmem_bus.dmem_wdata, 32'h1234);
      chk("sw_we", 32'(dmem_bus.dmem_we), 1);
      if (i == 3) dmem_bus.dmem_gnt = 1'b1;
      tick();
    end
    dmem_bus.dmem_gnt = 1'b0;
    chk("sw_done_req", 32'(dmem_bus.dmem_req), 0);
    chk("sw_done_stall", 32'(stall_mem), 0);
    tick();
    chk("sw_wb_regwrite", 32'(wb_regwrite), 0);

    // 4. misaligned lw 0x42
    issue(32'h42, 32'h0, 5'd9, C_LW, 1'b0);
    chk("mis_stall", 32'(stall_mem), 0);
    chk("mis_req", 32'(dmem_bus.dmem_req), 0);
    chk("mis_err_before", 32'(misalign_err), 0);
    chk("mis_mem_rw", 32'(mem_regwrite), 0);
    tick();
    chk("mis_err", 32'(misalign_err), 1);
    chk("mis_bubble", 32'(wb_valid), 0);
    chk("mis_req_after", 32'(dmem_bus.dmem_req), 0);

    // gnt and rvalid in the same REQ cycle
    push(32'hCAFEF00D, 5'd12, 1'b1);
    issue(32'h84, 32'h0, 5'd12, C_LW, 1'b0);
    tick();
    dmem_bus.dmem_gnt = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata = '0;
    chk("gr_done_stall", 32'(stall_mem), 0);
    tick();

    // 5. lw with no rvalid: timeout after 8 WAIT cycles
    push(32'h0, 5'd10, 1'b1);
    issue(32'h80, 32'h0, 5'd10, C_LW, 1'b0);
    tick();
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_stall", 32'(stall_mem), 1);
      chk("to_bus_err_early", 32'(bus_err), 0);
      tick();
    end
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_stall_released", 32'(stall_mem), 0);
    tick();
    chk("mis_err_sticky", 32'(misalign_err), 1);

    // 6. reset during WAIT
    issue(32'h90, 32'h0, 5'd11, C_LW, 1'b0);
    tick();
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    chk("rw_stall_pre", 32'(stall_mem), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rw_req", 32'(dmem_bus.dmem_req), 0);
    chk("rw_stall", 32'(stall_mem), 0);
    chk("rw_wb_valid", 32'(wb_valid), 0);
    chk("rw_bus_err_clr", 32'(bus_err), 0);
    chk("rw_mis_err_clr", 32'(misalign_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_idle_req", 32'(dmem_bus.dmem_req), 0);
    chk("rw_idle_stall", 32'(stall_mem), 0);
    push(32'h55, 5'd7, 1'b1);
    issue(32'h55, 32'h0, 5'd7, C_ALU, 1'b0);
    tick();
    tick();
    tick();

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
